// File: rtl/keypad_scanner_if.sv
// Keypad-side and turn-logic-side signals of the keypad scanner.
// The master modport is the scanner itself. The slave modport is the
// environment: the physical matrix plus the consumer of the key code.
interface keypad_scanner_if;
    logic [3:0] row_in;     // rows, active-low, asynchronous to clk
    logic [2:0] col_out;    // column strobes, active-low, one-cold
    logic [3:0] key_code;   // debounced key code, 0 = no key
    logic       key_valid;  // key_code is nonzero
    logic       key_pulse;  // one-cycle strobe on a new nonzero key

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_pulse
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner with frame-level debounce.
// Columns are strobed in turn. The rows are sampled once per column, on the
// last dwell cycle. One frame covers all three columns and yields 0 (no key
// or ghost/multi-press) or a single key code 1..12. The code is accepted once
// it has been identical for DEBOUNCE_SCANS consecutive frames.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,  // clocks per column, >= 4
    parameter int DEBOUNCE_SCANS = 4      // identical frames to accept, >= 1
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scanner_if.master   kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } state_t;

    logic [3:0]    row_meta_q, row_sync_q;
    state_t        state_q;
    logic [DW-1:0] dwell_q;
    logic [2:0]    col_q;
    logic [1:0]    acc_n_q;        // contacts seen this frame: 0, 1, 2 = many
    logic [3:0]    acc_code_q;     // code of the single contact, if any
    logic [3:0]    cand_q, cand_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_pulse_q;

    logic          dwell_last_s;
    logic          frame_end_s;
    logic [1:0]    col_idx_s;
    logic [2:0]    col_n_s;
    logic [3:0]    col_code_s;
    logic [2:0]    tot_s;
    logic [1:0]    sat_n_s;
    logic [3:0]    merged_code_s;
    logic [3:0]    frame_result_s;
    logic          accept_s;

    assign dwell_last_s = (dwell_q == DW'(SCAN_DIV - 1));
    assign frame_end_s  = dwell_last_s && (state_q == COL2);

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Column index of the state currently being scanned.
    always_comb begin
        case (state_q)
            COL0:    col_idx_s = 2'd0;
            COL1:    col_idx_s = 2'd1;
            COL2:    col_idx_s = 2'd2;
            default: col_idx_s = 2'd0;
        endcase
    end

    // Count the contacts in the driven column and remember the last code seen.
    always_comb begin
        col_n_s    = 3'd0;
        col_code_s = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                col_n_s    = col_n_s + 3'd1;
                col_code_s = 4'(3 * r) + {2'b00, col_idx_s} + 4'd1;
            end else begin
                col_n_s    = col_n_s;
            end
        end
    end

    // Merge this column into the frame tally; more than one contact yields 0.
    always_comb begin
        tot_s          = {1'b0, acc_n_q} + col_n_s;
        sat_n_s        = (tot_s >= 3'd2) ? 2'd2 : tot_s[1:0];
        merged_code_s  = (acc_n_q == 2'd0) ? col_code_s : acc_code_q;
        frame_result_s = (sat_n_s == 2'd1) ? merged_code_s : 4'd0;
    end

    // Debounce next state and accept decision, meaningful at frame end only.
    always_comb begin
        if (frame_result_s == cand_q) begin
            cand_d = cand_q;
            stab_d = (stab_q == SW'(DEBOUNCE_SCANS)) ? stab_q : stab_q + SW'(1);
        end else begin
            cand_d = frame_result_s;
            stab_d = SW'(1);
        end
        accept_s = frame_end_s && (stab_d == SW'(DEBOUNCE_SCANS)) &&
                   (cand_d != key_code_q);
    end

    // Column scan FSM: dwell counter, registered strobes and frame accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COL0;
            dwell_q    <= '0;
            col_q      <= 3'b110;
            acc_n_q    <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (dwell_last_s) begin
            dwell_q <= '0;
            case (state_q)
                COL0: begin
                    state_q <= COL1;
                    col_q   <= 3'b101;
                end
                COL1: begin
                    state_q <= COL2;
                    col_q   <= 3'b011;
                end
                COL2: begin
                    state_q <= COL0;
                    col_q   <= 3'b110;
                end
                default: begin
                    state_q <= COL0;
                    col_q   <= 3'b110;
                end
            endcase
            if (state_q == COL2) begin
                acc_n_q    <= 2'd0;
                acc_code_q <= 4'd0;
            end else begin
                acc_n_q    <= sat_n_s;
                acc_code_q <= merged_code_s;
            end
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    // Debounce state and registered key outputs, updated on frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q      <= 4'd0;
            stab_q      <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_pulse_q <= 1'b0;
        end else if (frame_end_s) begin
            cand_q <= cand_d;
            stab_q <= stab_d;
            if (accept_s) begin
                key_code_q  <= cand_d;
                key_valid_q <= (cand_d != 4'd0);
                key_pulse_q <= (cand_d != 4'd0);
            end else begin
                key_pulse_q <= 1'b0;
            end
        end else begin
            key_pulse_q <= 1'b0;
        end
    end

    assign kp.col_out   = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A combinational keypad model pulls rows low for pressed keys whose column
// is driven. The stimulus pushes each expected pulse (code and cycle) into a
// queue. A monitor pops the queue on every key_pulse.
module tb_keypad_scanner;

    localparam int FRAME = 12;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:1] keys;
    int          cyc;
    int          fr;
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];

    keypad_scanner_if kp_if ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.master)
    );

    always #5 clk = ~clk;

    // Keypad matrix: key at (r,c) has code 3r+c+1.
    always_comb begin
        kp_if.row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[3 * r + c + 1] && !kp_if.col_out[c]) kp_if.row_in[r] = 1'b0;
            end
        end
    end

    // Cycle index since the last reset; cycle 0 is the first after release.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        tick(FRAME * n);
        fr += n;
    endtask

    task automatic push(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic check_key(input string name, input int code, input int valid);
        @(negedge clk);
        check({name, "_code"},  int'(kp_if.key_code),  code);
        check({name, "_valid"}, int'(kp_if.key_valid), valid);
    endtask

    // Monitor: every pulse must match the oldest expected pulse.
    always @(negedge clk) begin
        if (!rst && kp_if.key_pulse) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'(kp_if.key_code), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_code",  int'(kp_if.key_code),  int'(e.code));
                check("pulse_cycle", cyc,                   e.cyc);
                check("pulse_valid", int'(kp_if.key_valid), 1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        keys = '0;
        fr   = 0;
        tick(3);
        rst = 1'b0;
        tick(7);
        // Test 1: reset in the middle of a scan
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check("rst_col",   int'(kp_if.col_out),   int'(3'b110));
        check("rst_code",  int'(kp_if.key_code),  0);
        check("rst_valid", int'(kp_if.key_valid), 0);
        check("rst_pulse", int'(kp_if.key_pulse), 0);
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("col_dwell", int'(kp_if.col_out), (k < 4) ? int'(3'b110) : int'(3'b101));
        end
        tick(8);
        fr = 1;

        // Test 2: clean press of "1", held for 10 frames
        keys[1] = 1'b1;
        push(4'd1, FRAME * (fr + 2));
        frames(10);
        check_key("hold1", 1, 1);

        // Test 3: release, then press "3"
        keys = '0;
        frames(1);
        check_key("rel_early", 1, 1);
        frames(1);
        check_key("rel", 0, 0);
        keys[3] = 1'b1;
        push(4'd3, FRAME * (fr + 2));
        frames(3);
        check_key("key3", 3, 1);

        // Test 4: bounce on key 12, then a steady press
        keys = '0;
        frames(2);
        check_key("rel3", 0, 0);
        keys[12] = 1'b1; frames(1);
        keys[12] = 1'b0; frames(1);
        keys[12] = 1'b1; frames(1);
        keys[12] = 1'b0; frames(3);
        check_key("bounce", 0, 0);
        keys[12] = 1'b1;
        push(4'd12, FRAME * (fr + 2));
        frames(2);
        check_key("key12", 12, 1);

        // Test 5: multi-press rejected, then single key accepted
        keys = '0;
        frames(2);
        check_key("rel12", 0, 0);
        keys[1] = 1'b1;
        keys[3] = 1'b1;
        frames(3);
        check_key("multi", 0, 0);
        keys[3] = 1'b0;
        push(4'd1, FRAME * (fr + 2));
        frames(2);
        check_key("multi_rel", 1, 1);

        // Test 6: direct change 1 -> 5, then reset mid-hold
        keys[1] = 1'b0;
        keys[5] = 1'b1;
        push(4'd5, FRAME * (fr + 2));
        frames(2);
        check_key("key5", 5, 1);
        frames(1);
        tick(5);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check("rst2_col",   int'(kp_if.col_out),   int'(3'b110));
        check("rst2_code",  int'(kp_if.key_code),  0);
        check("rst2_valid", int'(kp_if.key_valid), 0);
        check("rst2_pulse", int'(kp_if.key_pulse), 0);
        tick(1);
        rst = 1'b0;
        fr  = 0;
        push(4'd5, FRAME * 2);
        frames(3);
        check_key("key5_again", 5, 1);
        tick(24);
        check("pending_pulses", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
